alu_exec: RTL

- Execute-stage ALU of the RISC-V-style core with custom NN ops. It consumes the 4-bit ALUCtrl code from the ALU control decoder and operands from the ID/EX register.
- Single-cycle ops give a registered result one cycle after acceptance. MUL runs on an iterative shift-add multiplier and stalls the pipeline until done.
- The zero flag feeds beq resolution.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_exec_seq_multiplier.sv | 74 +++++++
 rtl/alu_exec.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU and the ALU control decoder:
// ALUCtrl op codes and the alu_exec FSM state encoding.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_MUL   = 4'b0110;
    localparam logic [3:0] ALU_RELU  = 4'b0111;
    localparam logic [3:0] ALU_LRELU = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_exec_seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier, one multiplier bit per step. Produces the
// low WIDTH bits of the product.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   synchronous active-low reset (clears all datapath state)
//   i_start   load operands, clear accumulator and counter
//   i_step    perform one shift-add iteration
//   i_abort   discard in-flight state
//   i_a, i_b  multiplicand / multiplier
//   o_last    the iteration performed this cycle is the final one
//   o_result  accumulator value after this cycle's iteration
//
// Build option: ALU_MUL_EARLY_TERM_EN -- finish as soon as no set multiplier
// bits remain, instead of always running WIDTH iterations.
// ---------------------------------------------------------------------------
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_result
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_result   = w_acc_next;

`ifdef ALU_MUL_EARLY_TERM_EN
    // Once at most bit 0 of the multiplier remains, this step finishes the
    // product (a zero multiplier adds nothing and also ends here).
    assign o_last = (r_cnt == LAST_CNT) || (r_mplier[WIDTH-1:1] == '0);
`else
    assign o_last = (r_cnt == LAST_CNT);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_abort) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec
// Execute-stage ALU. Single-cycle ops return a registered result the cycle
// after acceptance; MUL runs on seq_multiplier and stalls the pipeline.
//
//   state | meaning
//   IDLE  | ready, single-cycle ops issue back-to-back
//   MUL   | multiplier iterating, pipeline stalled
//   DONE  | product on data_o/valid_o, returns to IDLE
//
// Ports:
//   clk_i, rst_n_i       clock / synchronous active-low reset
//   valid_i, ALUCtrl_i   request and op code (unknown codes execute add)
//   data1_i, data2_i     operands A / B
//   flush_i              abort in-flight op, block acceptance
//   ready_o, stall_o     handshake / hazard-unit stall (combinational)
//   valid_o, data_o,     registered result pulse, result, result==0
//   zero_o
//
// Build option: ALU_MUL_EARLY_TERM_EN (see seq_multiplier).
// ---------------------------------------------------------------------------
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);

    alu_state_e       r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0] w_leaky;
    logic [WIDTH-1:0] w_alu_res;

    assign ready_o  = (r_state == ST_IDLE);
    assign w_is_mul = (ALUCtrl_i == ALU_MUL);
    assign w_accept = valid_i & ready_o & ~flush_i;
    assign stall_o  = (ready_o & valid_i & w_is_mul & ~flush_i) | (r_state == ST_MUL);

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign zero_o  = r_zero;

    assign w_leaky = $signed(data1_i) >>> LEAKY_SHIFT;

    always_comb begin
        w_alu_res = data1_i + data2_i;
        case (ALUCtrl_i)
            ALU_SUB:   w_alu_res = data1_i - data2_i;
            ALU_AND:   w_alu_res = data1_i & data2_i;
            ALU_OR:    w_alu_res = data1_i | data2_i;
            ALU_RELU:  w_alu_res = data1_i[WIDTH-1] ? '0 : data1_i;
            ALU_LRELU: w_alu_res = data1_i[WIDTH-1] ? w_leaky : data1_i;
            default:   ;
        endcase
    end

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_clk    (clk_i),
        .i_rst_n  (rst_n_i),
        .i_start  (w_accept & w_is_mul),
        .i_step   (r_state == ST_MUL),
        .i_abort  (flush_i),
        .i_a      (data1_i),
        .i_b      (data2_i),
        .o_last   (w_mul_last),
        .o_result (w_mul_res)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                        end else begin
                            r_valid <= 1'b1;
                            r_data  <= w_alu_res;
                            r_zero  <= (w_alu_res == '0);
                        end
                    end
                end
                ST_MUL: begin
                    if (flush_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_mul_last) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                        r_data  <= w_mul_res;
                        r_zero  <= (w_mul_res == '0);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
